multicycle_ctrl: RTL
====================

# multicycle_ctrl

- Main control FSM for the multicycle variant of the RV32I core.
- The datapath shares one unified instruction/data memory and one ALU across several cycles per instruction, using the architectural registers IR, OldPC, A, B, Data and ALUOut.
- This block sequences that datapath: it drives every mux select, write enable and ALU operation from the IR fields and the ALU ZERO flag.
- It sits between the IR decoder fields and the datapath.

## Interface

Parameters:
- None.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  7  IR[6:0].
- f3  in  3  IR[14:12].
- f7  in  7  IR[31:25].
- ZERO  in  1  ALU result == 0, combinational from current ALU inputs.
- mem_ready  in  1  memory access complete; used only with MEM_WAIT_EN.
- PC_WRITE  out  1  load PC from result bus.
- ADR_SRC  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MEM_WRITE  out  1  memory write strobe.
- IR_WRITE  out  1  load IR and OldPC.
- RES_SRC  out  2  result bus select: 00 = ALUOut, 01 = Data, 10 = ALU result.
- ALU_SRC_A  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = A, 11 = zero.
- ALU_SRC_B  out  2  ALU B select: 00 = B, 01 = imm, 10 = 4.
- ALU_CONTROL  out  4  ALU operation encoding:
  - 0000 add, 0001 sub, 0100 and, 0101 or, 0110 xor
  - 1000 slt, 1001 sltu, 1110 sll, 1101 srl, 1111 sra
- IMM_SRC  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J; decoded from op in every state.
- REG_WRITE  out  1  register file write.
- retire  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  sticky illegal-instruction flag.
- state  out  4  current state, for debug.

## Operation

States (4-bit encoding):
- FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10, JALR_ADR 11, JALR_PC 12, UPPER 13, TRAP 15.

Per-state behaviour (signals not listed are 0 / don't-care; all write enables default 0):
- FETCH: ADR_SRC=0, IR_WRITE=1, A=00, B=10, add, RES_SRC=10, PC_WRITE=1 → DECODE.
- DECODE: A=01, B=01, add, so ALUOut = OldPC + imm, the branch/jal target.
  - Load or store → MEMADR.
  - R-type → EXEC_R.
  - OP-IMM → EXEC_I.
  - Branch → BRANCH.
  - JAL → JAL.
  - JALR → JALR_ADR.
  - LUI or AUIPC → UPPER.
  - Any other op → TRAP.
- MEMADR: A=10, B=01, add → MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: ADR_SRC=1 → MEMWB.
- MEMWB: RES_SRC=01, REG_WRITE=1, retire → FETCH.
- MEMWRITE: ADR_SRC=1, MEM_WRITE=1, retire → FETCH.
- EXEC_R: A=10, B=00, ALU_CONTROL from f3/f7 (f3=000 with f7=0100000 gives sub) → ALUWB.
- EXEC_I: A=10, B=01, ALU_CONTROL from f3; f7 is consulted only for shifts → ALUWB.
- ALUWB: RES_SRC=00, REG_WRITE=1, retire → FETCH.
- BRANCH: A=10, B=00, RES_SRC=00, retire.
  - beq/bne use sub; blt/bge use slt; bltu/bgeu use sltu.
  - Branch taken when:
    - beq, bge, bgeu: ZERO=1.
    - bne, blt, bltu: ZERO=0.
  - PC_WRITE = taken. Next state FETCH.
- JAL: RES_SRC=00, PC_WRITE=1, A=01, B=10, add (ALUOut ← link) → ALUWB.
- JALR_ADR: A=10, B=01, add → JALR_PC.
- JALR_PC: RES_SRC=00, PC_WRITE=1, A=01, B=10, add → ALUWB.
- UPPER: B=01, add, A=11 for LUI, A=01 for AUIPC → ALUWB.
- TRAP: all enables 0, illegal=1; held until reset.

Illegal encodings (→ TRAP):
- Undefined opcode.
- R-type with f7 not in {0000000, 0100000}, or 0100000 with f3 not in {000, 101}.
- OP-IMM shift with invalid f7.
- Branch f3 ∈ {010, 011}.

## Timing

- Reset:
  - While reset is high, PC_WRITE, IR_WRITE, MEM_WRITE, REG_WRITE, retire and illegal are forced 0.
  - state = FETCH at the first edge with reset high; fetch begins on the cycle after release.
- Reset mid-instruction: the instruction is abandoned, no partial write is issued after the reset edge, and illegal clears.
- Cycles per instruction (zero-wait memory):
  - branch 3
  - R-type, OP-IMM, store, jal, lui, auipc 4
  - load, jalr 5
- retire is asserted in exactly one cycle per instruction.
- ALU_CONTROL and the BRANCH PC_WRITE are Mealy outputs (from f3/f7 and ZERO); all other outputs are Moore.

## Configuration

- MEM_WAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
  - In FETCH, IR_WRITE and PC_WRITE are asserted only in the cycle with mem_ready=1.
  - MEM_WRITE stays high for every wait cycle.
  - retire in MEMWRITE is asserted only in the mem_ready cycle.
- MEM_WAIT_EN undefined: mem_ready is ignored and every memory state lasts one cycle.

## Structure

- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - ALU_CONTROL encodings;
  - state enum;
  - ALU_SRC_A, ALU_SRC_B, RES_SRC and IMM_SRC select constants.
- One combinational sub-module, alu_decoder: inputs op, f3, f7 and the state class; outputs ALU_CONTROL and the illegal-encoding flag.

## Test plan

- Reset, then add x3,x1,x2 (0x002081B3), mem_ready=1 → states 0,1,6,8; ALU_CONTROL=0000 in EXEC_R; REG_WRITE=1 only in ALUWB; one retire.
- lw x3,0(x1) (0x0000A183) → states 0,1,2,3,4; ADR_SRC=1 in MEMREAD; RES_SRC=01 with REG_WRITE=1 in MEMWB.
- bne (op=1100011, f3=001): ZERO=1 → PC_WRITE=0 in BRANCH; ZERO=0 → PC_WRITE=1; ALU_CONTROL=0001 in both cases.
- MEM_WAIT_EN, sw with mem_ready low for 3 cycles in MEMWRITE → MEM_WRITE high 4 cycles, single retire, then FETCH.
- op=0000000 → TRAP with illegal=1 held 10+ cycles and no enables; reset → illegal=0, state=0.
- reset asserted in MEMWRITE → MEM_WRITE=0 that cycle; state=0 next cycle.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control path: opcodes, ALU encodings,
// FSM states and datapath select codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1110;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR_ADR = 4'd11,
        JALR_PC  = 4'd12,
        UPPER    = 4'd13,
        TRAP     = 4'd15
    } state_e;

    // Which ALU decode applies in the current state; everything else just adds.
    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_R,
        CLS_I,
        CLS_BRANCH
    } alu_class_e;

    function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic alt_sub,
                                             input logic alt_sra);
        case (f3)
            3'b000:  return alt_sub ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt_sra ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_LUI, OP_AUIPC:  return IMM_U;
            OP_JAL:            return IMM_J;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode from op/f3/f7 for the active state class, plus the
// illegal-encoding flag used by DECODE.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  alu_class_e  cls,
    output logic [3:0]  alu_control,
    output logic        illegal_enc
);

    logic f7_zero;
    logic f7_alt;

    assign f7_zero = (f7 == 7'b0000000);
    assign f7_alt  = (f7 == 7'b0100000);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        illegal_enc = 1'b0;
        case (op)
            OP_R:      illegal_enc = !(f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
            OP_IMM: begin
                if (f3 == 3'b001)
                    illegal_enc = !f7_zero;
                else if (f3 == 3'b101)
                    illegal_enc = !(f7_zero || f7_alt);
            end
            OP_BRANCH: illegal_enc = (f3[2:1] == 2'b01);
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ;
            default:   illegal_enc = 1'b1;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (cls)
            CLS_R:  alu_control = alu_arith(f3, f7_alt, f7_alt);
            // OP-IMM f3=000 carries immediate bits in f7, so it never selects sub.
            CLS_I:  alu_control = alu_arith(f3, 1'b0, f7_alt);
            CLS_BRANCH: begin
                case (f3[2:1])
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_SUB;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM. Define MEM_WAIT_EN to let FETCH, MEMREAD and
// MEMWRITE stall on mem_ready; otherwise every memory state takes one cycle.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic        ZERO,
    input  logic        mem_ready,
    output logic        PC_WRITE,
    output logic        ADR_SRC,
    output logic        MEM_WRITE,
    output logic        IR_WRITE,
    output logic [1:0]  RES_SRC,
    output logic [1:0]  ALU_SRC_A,
    output logic [1:0]  ALU_SRC_B,
    output logic [3:0]  ALU_CONTROL,
    output logic [2:0]  IMM_SRC,
    output logic        REG_WRITE,
    output logic        retire,
    output logic        illegal,
    output logic [3:0]  state
);

    state_e     cur;
    alu_class_e cls;
    logic       bad_enc;
    logic       mem_done;
    logic       taken;

`ifdef MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    alu_decoder u_alu_decoder (
        .op          (op),
        .f3          (f3),
        .f7          (f7),
        .cls         (cls),
        .alu_control (ALU_CONTROL),
        .illegal_enc (bad_enc)
    );

    // beq/bge/bgeu take on ZERO=1; bne/blt/bltu take on ZERO=0.
    assign taken = f3[2] ? (ZERO == f3[0]) : (ZERO != f3[0]);

    // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:    if (mem_done) cur <= DECODE;
                DECODE: begin
                    if (bad_enc) cur <= TRAP;
                    else begin
                        case (op)
                            OP_LOAD, OP_STORE: cur <= MEMADR;
                            OP_R:              cur <= EXEC_R;
                            OP_IMM:            cur <= EXEC_I;
                            OP_BRANCH:         cur <= BRANCH;
                            OP_JAL:            cur <= JAL;
                            OP_JALR:           cur <= JALR_ADR;
                            OP_LUI, OP_AUIPC:  cur <= UPPER;
                            default:           cur <= TRAP;
                        endcase
                    end
                end
                MEMADR:   cur <= (op == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_done) cur <= MEMWB;
                MEMWRITE: if (mem_done) cur <= FETCH;
                EXEC_R, EXEC_I, JAL, JALR_PC, UPPER: cur <= ALUWB;
                JALR_ADR: cur <= JALR_PC;
                MEMWB, ALUWB, BRANCH: cur <= FETCH;
                TRAP:     cur <= TRAP;
                default:  cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        PC_WRITE  = 1'b0;
        ADR_SRC   = 1'b0;
        MEM_WRITE = 1'b0;
        IR_WRITE  = 1'b0;
        REG_WRITE = 1'b0;
        retire    = 1'b0;
        RES_SRC   = RES_ALUOUT;
        ALU_SRC_A = SRCA_PC;
        ALU_SRC_B = SRCB_REG;
        cls       = CLS_ADD;
        case (cur)
            FETCH: begin
                IR_WRITE  = mem_done;
                PC_WRITE  = mem_done;
                ALU_SRC_B = SRCB_FOUR;
                RES_SRC   = RES_ALU;
            end
            DECODE: begin
                ALU_SRC_A = SRCA_OLDPC;
                ALU_SRC_B = SRCB_IMM;
            end
            MEMADR, JALR_ADR: begin
                ALU_SRC_A = SRCA_REG;
                ALU_SRC_B = SRCB_IMM;
            end
            MEMREAD:  ADR_SRC = 1'b1;
            MEMWB: begin
                RES_SRC   = RES_DATA;
                REG_WRITE = 1'b1;
                retire    = 1'b1;
            end
            MEMWRITE: begin
                ADR_SRC   = 1'b1;
                MEM_WRITE = 1'b1;
                retire    = mem_done;
            end
            EXEC_R: begin
                ALU_SRC_A = SRCA_REG;
                cls       = CLS_R;
            end
            EXEC_I: begin
                ALU_SRC_A = SRCA_REG;
                ALU_SRC_B = SRCB_IMM;
                cls       = CLS_I;
            end
            ALUWB: begin
                REG_WRITE = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                ALU_SRC_A = SRCA_REG;
                cls       = CLS_BRANCH;
                PC_WRITE  = taken;
                retire    = 1'b1;
            end
            JAL, JALR_PC: begin
                PC_WRITE  = 1'b1;
                ALU_SRC_A = SRCA_OLDPC;
                ALU_SRC_B = SRCB_FOUR;
            end
            UPPER: begin
                ALU_SRC_A = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                ALU_SRC_B = SRCB_IMM;
            end
            default: ;
        endcase
        // Reset must suppress writes in the very cycle it is raised, not one edge later.
        if (reset) begin
            PC_WRITE  = 1'b0;
            IR_WRITE  = 1'b0;
            MEM_WRITE = 1'b0;
            REG_WRITE = 1'b0;
            retire    = 1'b0;
        end
    end

    assign IMM_SRC = imm_src_of(op);
    assign illegal = (cur == TRAP) && !reset;
    assign state   = cur;

endmodule
